// File: rtl/stage_render_pkg.sv
// Shared constants, colour codes and FSM encoding for the stage renderer.
package stage_render_pkg;
   localparam logic [8:0] ORIGIN_X  = 9'd72;
   localparam logic [7:0] ORIGIN_Y  = 8'd32;
   localparam int         TILE      = 16;
   localparam int         FIELD     = 176;
   localparam int         NUM_BOMBS = 6;

   localparam logic [7:0] LAST_PIX  = 8'(FIELD - 1);
   localparam logic [2:0] LAST_BOMB = 3'(NUM_BOMBS - 1);

   localparam logic [2:0] COL_EXPLOSION = 3'b110;
   localparam logic [2:0] COL_GRASS     = 3'b010;
   localparam logic [2:0] COL_WALL      = 3'b111;
   localparam logic [2:0] COL_BRICK     = 3'b100;
   localparam logic [2:0] COL_OTHER     = 3'b011;
   localparam logic [2:0] COL_BOMB      = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_TILES  = 3'd1,
      ST_BLATCH = 3'd2,
      ST_BDRAW  = 3'd3,
      ST_FIN    = 3'd4
   } state_t;
endpackage

// File: rtl/stage_render_tile_colour.sv
// Combinational map-tile to palette lookup; an explosion overrides the tile.
module tile_colour
   import stage_render_pkg::*;
(
   input  logic [3:0] map_tile_id,
   input  logic       has_explosion,
   output logic [2:0] colour
);

   // palette selection
   always_comb begin
      colour = COL_OTHER;
      if (has_explosion) begin
         colour = COL_EXPLOSION;
      end else begin
         case (map_tile_id)
            4'd0:    colour = COL_GRASS;
            4'd1:    colour = COL_WALL;
            4'd2:    colour = COL_BRICK;
            default: colour = COL_OTHER;
         endcase
      end
   end

endmodule

// File: rtl/stage_render.sv
// Frame renderer: scans the tile field, then overlays each enabled bomb sprite,
// writing every pixel to the VGA adapter with one cycle of latency.
module stage_render
   import stage_render_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [8:0]  X,
   output logic [7:0]  Y,
   input  logic [3:0]  map_tile_id,
   input  logic        has_explosion,
   output logic [2:0]  bomb_id,
   input  logic [17:0] bomb_info,
   output logic [8:0]  vga_x,
   output logic [7:0]  vga_y,
   output logic [2:0]  colour,
   output logic        plot,
   output logic        busy,
   output logic        done
);

   state_t      state_r, state_nxt_s;
   logic [7:0]  px_r, py_r, px_nxt_s, py_nxt_s;
   logic [3:0]  ox_r, oy_r, ox_nxt_s, oy_nxt_s;
   logic [2:0]  bid_r, bid_nxt_s;
   logic [16:0] bpos_r, bpos_nxt_s;
   logic [8:0]  vx_r, vx_nxt_s;
   logic [7:0]  vy_r, vy_nxt_s;
   logic [2:0]  col_r, col_nxt_s, tile_col_s;
   logic        plot_r, plot_nxt_s, done_r, done_nxt_s, busy_r;
   logic        in_sprite_s;

   tile_colour u_tile_colour (
      .map_tile_id   (map_tile_id),
      .has_explosion (has_explosion),
      .colour        (tile_col_s)
   );

   assign X       = (state_r == ST_TILES) ? (ORIGIN_X + {1'b0, px_r}) : 9'd0;
   assign Y       = (state_r == ST_TILES) ? (ORIGIN_Y + py_r) : 8'd0;
   assign bomb_id = bid_r;
   assign vga_x   = vx_r;
   assign vga_y   = vy_r;
   assign colour  = col_r;
   assign plot    = plot_r;
   assign busy    = busy_r;
   assign done    = done_r;

   // the 2-pixel transparent border leaves a 12x12 solid sprite
   assign in_sprite_s = (ox_r >= 4'd2) && (ox_r <= 4'd13) && (oy_r >= 4'd2) && (oy_r <= 4'd13);

   // next-state, counter and pixel-output computation
   always_comb begin
      state_nxt_s = state_r;
      px_nxt_s    = px_r;
      py_nxt_s    = py_r;
      ox_nxt_s    = ox_r;
      oy_nxt_s    = oy_r;
      bid_nxt_s   = bid_r;
      bpos_nxt_s  = bpos_r;
      vx_nxt_s    = 9'd0;
      vy_nxt_s    = 8'd0;
      col_nxt_s   = 3'd0;
      plot_nxt_s  = 1'b0;
      done_nxt_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_TILES;
               px_nxt_s    = 8'd0;
               py_nxt_s    = 8'd0;
               bid_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_TILES: begin
            vx_nxt_s   = X;
            vy_nxt_s   = Y;
            col_nxt_s  = tile_col_s;
            plot_nxt_s = 1'b1;
            if (px_r == LAST_PIX) begin
               px_nxt_s = 8'd0;
               if (py_r == LAST_PIX) begin
                  py_nxt_s    = 8'd0;
                  bid_nxt_s   = 3'd0;
                  state_nxt_s = ST_BLATCH;
               end else begin
                  py_nxt_s = py_r + 8'd1;
               end
            end else begin
               px_nxt_s = px_r + 8'd1;
            end
         end
         ST_BLATCH: begin
            bpos_nxt_s = bomb_info[17:1];
            if (bomb_info[0]) begin
               ox_nxt_s    = 4'd0;
               oy_nxt_s    = 4'd0;
               state_nxt_s = ST_BDRAW;
            end else if (bid_r == LAST_BOMB) begin
               state_nxt_s = ST_FIN;
            end else begin
               bid_nxt_s = bid_r + 3'd1;
            end
         end
         ST_BDRAW: begin
            vx_nxt_s   = bpos_r[8:0] + {5'd0, ox_r};
            vy_nxt_s   = bpos_r[16:9] + {4'd0, oy_r};
            col_nxt_s  = COL_BOMB;
            plot_nxt_s = in_sprite_s;
            if (ox_r == 4'd15) begin
               ox_nxt_s = 4'd0;
               if (oy_r == 4'd15) begin
                  oy_nxt_s = 4'd0;
                  if (bid_r == LAST_BOMB) begin
                     state_nxt_s = ST_FIN;
                  end else begin
                     bid_nxt_s   = bid_r + 3'd1;
                     state_nxt_s = ST_BLATCH;
                  end
               end else begin
                  oy_nxt_s = oy_r + 4'd1;
               end
            end else begin
               ox_nxt_s = ox_r + 4'd1;
            end
         end
         ST_FIN: begin
            done_nxt_s  = 1'b1;
            bid_nxt_s   = 3'd0;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // state, counters and registered VGA outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         px_r    <= 8'd0;
         py_r    <= 8'd0;
         ox_r    <= 4'd0;
         oy_r    <= 4'd0;
         bid_r   <= 3'd0;
         bpos_r  <= 17'd0;
         vx_r    <= 9'd0;
         vy_r    <= 8'd0;
         col_r   <= 3'd0;
         plot_r  <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         px_r    <= px_nxt_s;
         py_r    <= py_nxt_s;
         ox_r    <= ox_nxt_s;
         oy_r    <= oy_nxt_s;
         bid_r   <= bid_nxt_s;
         bpos_r  <= bpos_nxt_s;
         vx_r    <= vx_nxt_s;
         vy_r    <= vy_nxt_s;
         col_r   <= col_nxt_s;
         plot_r  <= plot_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_stage_render.sv
// Self-checking bench: a frame-level model lists every expected plot, and a
// single monitor compares each DUT plot against it.
module tb_stage_render;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [8:0]  X;
   logic [7:0]  Y;
   logic [3:0]  map_tile_id;
   logic        has_explosion;
   logic [2:0]  bomb_id;
   logic [17:0] bomb_info;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  colour;
   logic        plot, busy, done;

   stage_render dut (
      .clk(clk), .reset(reset), .start(start), .X(X), .Y(Y),
      .map_tile_id(map_tile_id), .has_explosion(has_explosion),
      .bomb_id(bomb_id), .bomb_info(bomb_info),
      .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
      .busy(busy), .done(done)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int n_plots, n_done, first_plot_edge, last_plot_edge, done_edge;
   bit mon_en = 1'b0;
   logic [19:0] exp_q[$];

   logic [3:0]  tmap [0:10][0:10];
   logic        expl [0:10][0:10];
   logic [17:0] btab [0:7];
   int tx_c, ty_c;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // bomb-block stand-in: answers for the queried (X, Y) in the same cycle
   always_comb begin
      map_tile_id   = 4'd0;
      has_explosion = 1'b0;
      tx_c = 0;
      ty_c = 0;
      if (X >= 9'd72 && X < 9'd248 && Y >= 8'd32 && Y < 8'd208) begin
         tx_c = (int'(X) - 72) / 16;
         ty_c = (int'(Y) - 32) / 16;
         map_tile_id   = tmap[ty_c][tx_c];
         has_explosion = expl[ty_c][tx_c];
      end
   end
   assign bomb_info = btab[bomb_id];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // expected plot list for one whole frame, straight from the drawing rules
   task automatic build_model();
      logic [2:0] c;
      int tx, ty;
      exp_q.delete();
      for (int py = 0; py < 176; py++) begin
         for (int px = 0; px < 176; px++) begin
            tx = px / 16;
            ty = py / 16;
            if (expl[ty][tx]) c = 3'b110;
            else if (tmap[ty][tx] == 4'd0) c = 3'b010;
            else if (tmap[ty][tx] == 4'd1) c = 3'b111;
            else if (tmap[ty][tx] == 4'd2) c = 3'b100;
            else c = 3'b011;
            exp_q.push_back({9'(72 + px), 8'(32 + py), c});
         end
      end
      for (int b = 0; b < 6; b++) begin
         if (btab[b][0]) begin
            for (int oy = 2; oy <= 13; oy++) begin
               for (int ox = 2; ox <= 13; ox++) begin
                  exp_q.push_back({btab[b][9:1] + 9'(ox), btab[b][17:10] + 8'(oy), 3'b000});
               end
            end
         end
      end
   endtask

   // the one compare process: every plotted pixel against the model
   always @(negedge clk) begin
      if (mon_en) begin
         if (plot === 1'b1) begin
            n_plots++;
            if (n_plots == 1) first_plot_edge = edge_cnt;
            last_plot_edge = edge_cnt;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL plot_extra got %0d,%0d,%b expected no plot", vga_x, vga_y, colour);
            end else if ({vga_x, vga_y, colour} !== exp_q[0]) begin
               errors++;
               $display("FAIL plot_data got %0d,%0d,%b expected %0d,%0d,%b",
                        vga_x, vga_y, colour, exp_q[0][19:11], exp_q[0][10:3], exp_q[0][2:0]);
               void'(exp_q.pop_front());
            end else begin
               void'(exp_q.pop_front());
            end
         end
         if (done === 1'b1) begin
            n_done++;
            done_edge = edge_cnt;
         end
         checks++;
         if (bomb_id > 3'd5) begin
            errors++;
            $display("FAIL bomb_id_range got %0d expected <=5", bomb_id);
         end
      end
   end

   task automatic run_frame(input int nb, input bit repulse);
      int s0;
      n_plots = 0;
      n_done  = 0;
      done_edge = 0;
      first_plot_edge = 0;
      last_plot_edge = 0;
      @(negedge clk); #1;
      s0 = edge_cnt;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 33000; i++) begin
         @(negedge clk); #1;
         if (i == 100) chk("busy_mid", 32'(busy), 32'd1);
         if (repulse && i == 500) start = 1'b1;
         if (i == 501) start = 1'b0;
         if (n_done > 0) break;
      end
      repeat (10) @(negedge clk);
      #1;
      chk("done_count", n_done, 1);
      chk("plot_count", n_plots, 30976 + 144 * nb);
      chk("model_left", exp_q.size(), 0);
      chk("first_latency", first_plot_edge - s0, 2);
      chk("frame_length", done_edge - s0, 30976 + 6 + 256 * nb + 2);
      chk("busy_after", 32'(busy), 32'd0);
      if (nb == 0) chk("done_after_tiles", done_edge - last_plot_edge, 7);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 11; c++) begin
            tmap[r][c] = 4'd0;
            expl[r][c] = 1'b0;
         end
      for (int b = 0; b < 8; b++) btab[b] = 18'd0;
      btab[6] = {8'd60, 9'd150, 1'b1};
      btab[7] = {8'd70, 9'd160, 1'b1};
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_X", 32'(X), 32'd0);
      chk("rst_Y", 32'(Y), 32'd0);
      chk("rst_bomb_id", 32'(bomb_id), 32'd0);
      chk("rst_vga", {12'd0, vga_x, vga_y, colour}, 32'd0);
      chk("rst_ctrl", {29'd0, plot, busy, done}, 32'd0);
      reset = 1'b0;

      // frame 1: plain field, no bombs, start re-pulsed while busy
      build_model();
      chk("model1_size", exp_q.size(), 30976);
      chk("model1_first", 32'(exp_q[0]), 32'({9'd72, 8'd32, 3'b010}));
      mon_en = 1'b1;
      run_frame(0, 1'b1);

      // frame 2 setup: coloured tiles, explosion, bomb 4 at (104,48)
      tmap[0][1] = 4'd2;
      tmap[0][2] = 4'd2;
      expl[0][2] = 1'b1;
      tmap[0][3] = 4'd1;
      tmap[0][4] = 4'd9;
      btab[4] = {8'd48, 9'd104, 1'b1};
      build_model();
      chk("model2_size", exp_q.size(), 31120);
      chk("model2_brick", 32'(exp_q[16]), 32'({9'd88, 8'd32, 3'b100}));
      chk("model2_brick_end", 32'(exp_q[15 * 176 + 31]), 32'({9'd103, 8'd47, 3'b100}));
      chk("model2_expl", 32'(exp_q[32]), 32'({9'd104, 8'd32, 3'b110}));
      chk("model2_wall", 32'(exp_q[48]), 32'({9'd120, 8'd32, 3'b111}));
      chk("model2_other", 32'(exp_q[64]), 32'({9'd136, 8'd32, 3'b011}));
      chk("model2_bomb_first", 32'(exp_q[30976]), 32'({9'd106, 8'd50, 3'b000}));
      chk("model2_bomb_last", 32'(exp_q[31119]), 32'({9'd117, 8'd61, 3'b000}));

      // aborted frame: reset (with start held) once 1000 pixels are out
      n_plots = 0;
      n_done  = 0;
      @(negedge clk); #1;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         if (n_plots >= 1000) break;
      end
      chk("abort_reached", n_plots, 1000);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk); #1;
      chk("abort_plot", 32'(plot), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      chk("abort_no_done", n_done, 0);
      chk("abort_plots_frozen", n_plots, 1000);
      chk("abort_idle", 32'(busy), 32'd0);

      // frame 2 proper, after the abort
      build_model();
      run_frame(1, 1'b0);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
